// File: rtl/interframe_ctrl.sv
// CAN interframe sequencer: intermission, overload frames, bus idle and SOF permission.
// Define OVL_STATS_EN to add the saturating ovlCount output.
module interframe_ctrl #(
  parameter int MAX_LOCAL_OVL = 2,
  parameter int STUCK_LIMIT   = 13
) (
  input  logic       samplePoint,
  input  logic       nReset,
  input  logic       canRX,
  input  logic       eofDone,
  input  logic       rxNotReady,
  input  logic       isError,
  output logic       isOverload,
  output logic       overloadTX,
  output logic       txAllowed,
  output logic       sofDetect,
  output logic       stuckErr
`ifdef OVL_STATS_EN
  ,
  output logic [7:0] ovlCount
`endif
);

  localparam int CNT_W = (STUCK_LIMIT > 8) ? $clog2(STUCK_LIMIT) : 3;
  localparam int LCL_W = $clog2(MAX_LOCAL_OVL + 2);

  typedef enum logic [2:0] {
    WAIT_EOF     = 3'd0,
    INTERMISSION = 3'd1,
    OVL_FLAG     = 3'd2,
    OVL_WAIT_REC = 3'd3,
    OVL_DELIM    = 3'd4,
    BUS_IDLE     = 3'd5
  } state_t;

  state_t             state_r;
  state_t             nextState_s;
  logic [CNT_W-1:0]   bitCnt_r;
  logic [CNT_W-1:0]   nextBitCnt_s;
  logic [LCL_W-1:0]   localCnt_r;
  logic [LCL_W-1:0]   nextLocalCnt_s;
  logic               localReq_s;
  logic               sofPulse_s;
  logic               stuckPulse_s;

  // Next-state, counter and pulse decode for one sampled bit
  always_comb begin
    nextState_s    = state_r;
    nextBitCnt_s   = bitCnt_r;
    nextLocalCnt_s = localCnt_r;
    sofPulse_s     = 1'b0;
    stuckPulse_s   = 1'b0;
    localReq_s     = rxNotReady && (localCnt_r < LCL_W'(MAX_LOCAL_OVL));

    if (isError) begin
      nextState_s    = WAIT_EOF;
      nextBitCnt_s   = CNT_W'(0);
      nextLocalCnt_s = LCL_W'(0);
    end else begin
      case (state_r)
        WAIT_EOF: begin
          if (eofDone) begin
            nextBitCnt_s = CNT_W'(0);
            if (localReq_s) begin
              nextState_s    = OVL_FLAG;
              nextLocalCnt_s = localCnt_r + LCL_W'(1);
            end else begin
              nextState_s = INTERMISSION;
            end
          end else begin
            nextState_s = WAIT_EOF;
          end
        end
        INTERMISSION: begin
          // A local request wins over a simultaneous dominant bit so it is counted
          if ((bitCnt_r == CNT_W'(0)) && localReq_s) begin
            nextState_s    = OVL_FLAG;
            nextBitCnt_s   = CNT_W'(0);
            nextLocalCnt_s = localCnt_r + LCL_W'(1);
          end else if ((bitCnt_r < CNT_W'(2)) && !canRX) begin
            nextState_s  = OVL_FLAG;
            nextBitCnt_s = CNT_W'(0);
          end else if (bitCnt_r >= CNT_W'(2)) begin
            nextBitCnt_s   = CNT_W'(0);
            nextLocalCnt_s = LCL_W'(0);
            if (!canRX) begin
              sofPulse_s  = 1'b1;
              nextState_s = WAIT_EOF;
            end else begin
              nextState_s = BUS_IDLE;
            end
          end else begin
            nextBitCnt_s = bitCnt_r + CNT_W'(1);
          end
        end
        OVL_FLAG: begin
          if (bitCnt_r >= CNT_W'(5)) begin
            nextState_s  = OVL_WAIT_REC;
            nextBitCnt_s = CNT_W'(0);
          end else begin
            nextBitCnt_s = bitCnt_r + CNT_W'(1);
          end
        end
        OVL_WAIT_REC: begin
          if (canRX) begin
            nextState_s  = OVL_DELIM;
            nextBitCnt_s = CNT_W'(1);
          end else if (bitCnt_r >= CNT_W'(STUCK_LIMIT - 1)) begin
            stuckPulse_s = 1'b1;
            nextState_s  = WAIT_EOF;
            nextBitCnt_s = CNT_W'(0);
          end else begin
            nextBitCnt_s = bitCnt_r + CNT_W'(1);
          end
        end
        OVL_DELIM: begin
          if (!canRX) begin
            nextState_s  = OVL_FLAG;
            nextBitCnt_s = CNT_W'(0);
          end else if (bitCnt_r >= CNT_W'(7)) begin
            nextState_s  = INTERMISSION;
            nextBitCnt_s = CNT_W'(0);
          end else begin
            nextBitCnt_s = bitCnt_r + CNT_W'(1);
          end
        end
        BUS_IDLE: begin
          nextLocalCnt_s = LCL_W'(0);
          nextBitCnt_s   = CNT_W'(0);
          if (!canRX) begin
            sofPulse_s  = 1'b1;
            nextState_s = WAIT_EOF;
          end else begin
            nextState_s = BUS_IDLE;
          end
        end
        default: begin
          nextState_s    = WAIT_EOF;
          nextBitCnt_s   = CNT_W'(0);
          nextLocalCnt_s = LCL_W'(0);
        end
      endcase
    end
  end

  // State, counters and registered outputs (outputs decode the next state)
  always_ff @(posedge samplePoint or negedge nReset) begin
    if (!nReset) begin
      state_r    <= WAIT_EOF;
      bitCnt_r   <= CNT_W'(0);
      localCnt_r <= LCL_W'(0);
      isOverload <= 1'b0;
      overloadTX <= 1'b0;
      txAllowed  <= 1'b0;
      sofDetect  <= 1'b0;
      stuckErr   <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      bitCnt_r   <= nextBitCnt_s;
      localCnt_r <= nextLocalCnt_s;
      isOverload <= (nextState_s == OVL_FLAG) || (nextState_s == OVL_WAIT_REC) ||
                    (nextState_s == OVL_DELIM);
      overloadTX <= (nextState_s == OVL_FLAG);
      txAllowed  <= (nextState_s == BUS_IDLE) ||
                    ((nextState_s == INTERMISSION) && (nextBitCnt_s == CNT_W'(2)));
      sofDetect  <= sofPulse_s;
      stuckErr   <= stuckPulse_s;
    end
  end

`ifdef OVL_STATS_EN
  // Saturating count of overload-flag entries, survives error frames
  always_ff @(posedge samplePoint or negedge nReset) begin
    if (!nReset) begin
      ovlCount <= 8'd0;
    end else if ((nextState_s == OVL_FLAG) && (state_r != OVL_FLAG) &&
                 (ovlCount != 8'hFF)) begin
      ovlCount <= ovlCount + 8'd1;
    end else begin
      ovlCount <= ovlCount;
    end
  end
`endif

endmodule

// File: doc/interframe_ctrl.md
Name: interframe_ctrl

Overview:
- Sequences the interframe space of the CAN controller: intermission, overload frames and return to bus idle.
- Sits between the end-of-frame logic and the overload-frame generator; drives that generator's isOverload request.
- Decides when the node may start transmitting: SOF allowed or suspended.
- Yields unconditionally to the error-frame path (isError has priority).

Parameters:
- MAX_LOCAL_OVL, 2, maximum consecutive locally requested overload frames (reactive ones unlimited).
- STUCK_LIMIT, 13, dominant bits tolerated while waiting for recessive after own flag before stuckErr.

Ports:
- samplePoint  input  1  bit clock, one rising edge per sampled bit
- nReset  input  1  asynchronous reset, active low
- canRX  input  1  sampled bus level (0 = dominant)
- eofDone  input  1  pulse: last EOF bit sampled this edge
- rxNotReady  input  1  receiver requests a delay (local overload)
- isError  input  1  error frame active, overrides everything
- isOverload  output  1  overload frame in progress (to overload generator)
- overloadTX  output  1  1 = drive dominant this bit (own overload flag)
- txAllowed  output  1  SOF may be sent at next bit
- sofDetect  output  1  one-cycle pulse: dominant seen at 3rd intermission bit or in BUS_IDLE
- stuckErr  output  1  one-cycle pulse: dominant persisted STUCK_LIMIT bits after flag

Behaviour:
- All transitions on rising samplePoint; nReset low asynchronously forces state WAIT_EOF and all outputs 0; bit counter, localCnt (local overload count) cleared.
- States: WAIT_EOF, INTERMISSION, OVL_FLAG, OVL_WAIT_REC, OVL_DELIM, BUS_IDLE.
- WAIT_EOF: eofDone=1 -> INTERMISSION, bitCnt=0. If rxNotReady=1 at the eofDone edge and localCnt<MAX_LOCAL_OVL -> OVL_FLAG directly, localCnt+1.
- INTERMISSION (3 bits, bitCnt 0..2):
  - canRX=0 at bitCnt 0 or 1 -> OVL_FLAG (reactive; localCnt unchanged).
  - rxNotReady=1 at bitCnt 0 with localCnt<MAX_LOCAL_OVL -> OVL_FLAG, localCnt+1.
  - canRX=0 at bitCnt 2 -> sofDetect pulse, -> WAIT_EOF, localCnt=0.
  - bitCnt 2 recessive -> BUS_IDLE.
- OVL_FLAG: isOverload=1, overloadTX=1 for exactly 6 edges, then -> OVL_WAIT_REC with overloadTX=0.
- OVL_WAIT_REC: isOverload=1; count dominant bits.
  - First canRX=1 -> OVL_DELIM, bitCnt=1 (this bit is delimiter bit 1).
  - Count reaching STUCK_LIMIT -> stuckErr pulse, -> WAIT_EOF.
- OVL_DELIM: isOverload=1.
  - Recessive for 8 bits total -> INTERMISSION, bitCnt=0.
  - Dominant at any delimiter bit -> OVL_FLAG (reactive restart).
- BUS_IDLE: txAllowed=1; localCnt=0. canRX=0 -> sofDetect, -> WAIT_EOF.
- txAllowed is also 1 during INTERMISSION bitCnt 2; 0 in all other states.
- isError=1 at any edge: -> WAIT_EOF, outputs 0, counters cleared, no pulses. Overrides same-edge eofDone.
- Simultaneous canRX=0 and rxNotReady at intermission bit 0: a single overload, counted as local.
- rxNotReady at the limit: ignored; normal sequencing continues.

Optional Feature:
- OVL_STATS_EN defined: adds output ovlCount [7:0].
  - Increments on each entry to OVL_FLAG and saturates at 255.
  - Cleared only by nReset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: nReset=0 mid-OVL_FLAG -> isOverload=0, overloadTX=0 immediately. Release, eofDone, 3 recessive bits -> BUS_IDLE, txAllowed=1.
- eofDone with rxNotReady=1 -> 6 edges overloadTX=1; 8 recessive -> INTERMISSION. rxNotReady again -> second overload. Third request ignored -> BUS_IDLE.
- eofDone, canRX=0 at intermission bit 1 -> reactive overload; 6 dominant; 4 more dominant (superposition); 8 recessive -> intermission resumes.
- Intermission bit 2 dominant -> sofDetect pulse 1 cycle, state WAIT_EOF, txAllowed=0.
- After own flag, hold canRX=0 for 13 bits -> stuckErr pulse at the 13th, return to WAIT_EOF.
- isError=1 during OVL_DELIM -> all outputs 0 next edge; with OVL_STATS_EN, ovlCount reflects the 1 overload entered.
